// File: rtl/fpmul_pkg.sv
// Shared definitions for the FP multiplier assemble stage: default field widths,
// round-mode encodings and the overflow result patterns.
package fpmul_pkg;

  localparam int WEXP_DEF = 8;
  localparam int WSIG_DEF = 23;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } roundmode_e;

  function automatic int fp_width(input int wexp, input int wsig);
    return 1 + wexp + wsig;
  endfunction

  // Exponent all ones, significand zero (sign excluded)
  function automatic logic [63:0] fp_inf(input int wexp, input int wsig);
    return ((64'd1 << wexp) - 64'd1) << wsig;
  endfunction

  // Largest finite magnitude: exponent 1..10, significand all ones
  function automatic logic [63:0] fp_largest(input int wexp, input int wsig);
    return (((64'd1 << wexp) - 64'd2) << wsig) | ((64'd1 << wsig) - 64'd1);
  endfunction

endpackage

// File: rtl/fpmul_assemble_pipe_if.sv
// Upstream and downstream handshake bundle of the assemble stage.
// FPMUL_STICKY_FLAGS_EN adds the sticky flag clear/status signals.
interface fpmul_assemble_pipe_if #(
  parameter int WEXP = 8,
  parameter int WSIG = 23
);
  localparam int WIDTH = 1 + WEXP + WSIG;

  logic             in_valid;
  logic             in_ready;
  logic [WSIG-1:0]  roundprod;
  logic [WEXP-1:0]  shiftexp;
  logic             sign;
  logic [WIDTH-2:0] special;
  logic             specialsign;
  logic             specialcase;
  logic             specialsigncase;
  logic [1:0]       roundmode;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_ovf;
  logic             y_special;
`ifdef FPMUL_STICKY_FLAGS_EN
  logic             flag_clr;
  logic             sticky_ovf;
  logic             sticky_special;
`endif

  modport master (
    output in_valid, roundprod, shiftexp, sign, special, specialsign,
           specialcase, specialsigncase, roundmode, overflow, out_ready,
`ifdef FPMUL_STICKY_FLAGS_EN
    output flag_clr,
    input  sticky_ovf, sticky_special,
`endif
    input  in_ready, out_valid, y, y_ovf, y_special
  );

  modport slave (
    input  in_valid, roundprod, shiftexp, sign, special, specialsign,
           specialcase, specialsigncase, roundmode, overflow, out_ready,
`ifdef FPMUL_STICKY_FLAGS_EN
    input  flag_clr,
    output sticky_ovf, sticky_special,
`endif
    output in_ready, out_valid, y, y_ovf, y_special
  );

endinterface

// File: rtl/fpmul_skid_buf.sv
// Two-entry valid/ready skid buffer: main register drives the output, skid register
// absorbs one beat under back-pressure so in_ready never depends on out_ready.
module fpmul_skid_buf #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_r, skid_valid_r;
  logic [W-1:0] main_data_r, skid_data_r;
  logic         main_valid_s, skid_valid_s;
  logic [W-1:0] main_data_s, skid_data_s;
  logic         accept_s, drain_s;

  assign in_ready  = !skid_valid_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;
  assign accept_s  = in_valid & !skid_valid_r;
  assign drain_s   = main_valid_r & out_ready;

  // Next-state of the two storage slots; accept is only possible while skid is empty
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    if (drain_s && skid_valid_r) begin
      main_valid_s = 1'b1;
      main_data_s  = skid_data_r;
      skid_valid_s = 1'b0;
    end else if (drain_s || !main_valid_r) begin
      main_valid_s = accept_s;
      if (accept_s) begin
        main_data_s = in_data;
      end else begin
        main_data_s = main_data_r;
      end
    end else if (accept_s) begin
      skid_valid_s = 1'b1;
      skid_data_s  = in_data;
    end else begin
      skid_valid_s = skid_valid_r;
      skid_data_s  = skid_data_r;
    end
  end

  // Storage registers with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      main_data_r  <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
    end
  end

endmodule

// File: rtl/fpmul_assemble_pipe.sv
// Final FP multiplier stage: picks special / overflow / rounded result and registers it
// behind a skid buffer. Define FPMUL_STICKY_FLAGS_EN for sticky overflow/special flags.
module fpmul_assemble_pipe
  import fpmul_pkg::*;
#(
  parameter int WEXP = WEXP_DEF,
  parameter int WSIG = WSIG_DEF
) (
  input logic                clk,
  input logic                reset,
  fpmul_assemble_pipe_if.slave bus
);

  localparam int WIDTH = fp_width(WEXP, WSIG);
  localparam logic [63:0] INF_W = fp_inf(WEXP, WSIG);
  localparam logic [63:0] LARGEST_W = fp_largest(WEXP, WSIG);
  localparam logic [WIDTH-2:0] INF = INF_W[WIDTH-2:0];
  localparam logic [WIDTH-2:0] LARGEST = LARGEST_W[WIDTH-2:0];

  logic             sel_sign_s;
  logic [WIDTH-2:0] ovf_body_s;
  logic [WIDTH-2:0] body_s;
  logic             is_ovf_s;
  logic [WIDTH+1:0] in_data_s;
  logic [WIDTH+1:0] out_data_s;

  // Overflow saturation uses the raw product sign, not the special-case sign
  always_comb begin
    ovf_body_s = INF;
    case (roundmode_e'(bus.roundmode))
      RM_RNE:  ovf_body_s = INF;
      RM_RZ:   ovf_body_s = LARGEST;
      RM_RUP:  ovf_body_s = bus.sign ? LARGEST : INF;
      RM_RDN:  ovf_body_s = bus.sign ? INF : LARGEST;
      default: ovf_body_s = INF;
    endcase
  end

  // Result selection: special beats overflow beats the rounded value
  always_comb begin
    sel_sign_s = bus.specialsigncase ? bus.specialsign : bus.sign;
    is_ovf_s   = !bus.specialcase && bus.overflow;
    if (bus.specialcase) begin
      body_s = bus.special;
    end else if (bus.overflow) begin
      body_s = ovf_body_s;
    end else begin
      body_s = {bus.shiftexp, bus.roundprod};
    end
  end

  assign in_data_s = {is_ovf_s, bus.specialcase, sel_sign_s, body_s};

  fpmul_skid_buf #(.W(WIDTH + 2)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_data_s),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_data_s)
  );

  assign bus.y         = out_data_s[WIDTH-1:0];
  assign bus.y_special = out_data_s[WIDTH];
  assign bus.y_ovf     = out_data_s[WIDTH+1];

`ifdef FPMUL_STICKY_FLAGS_EN
  logic sticky_ovf_r, sticky_special_r;
  logic xfer_s;

  assign xfer_s             = bus.out_valid & bus.out_ready;
  assign bus.sticky_ovf     = sticky_ovf_r;
  assign bus.sticky_special = sticky_special_r;

  // Sticky flags: a flagged output transfer overrides a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_ovf_r     <= 1'b0;
      sticky_special_r <= 1'b0;
    end else begin
      if (xfer_s && bus.y_ovf) begin
        sticky_ovf_r <= 1'b1;
      end else if (bus.flag_clr) begin
        sticky_ovf_r <= 1'b0;
      end else begin
        sticky_ovf_r <= sticky_ovf_r;
      end
      if (xfer_s && bus.y_special) begin
        sticky_special_r <= 1'b1;
      end else if (bus.flag_clr) begin
        sticky_special_r <= 1'b0;
      end else begin
        sticky_special_r <= sticky_special_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpmul_assemble_pipe.sv
// Directed bench for fpmul_assemble_pipe (WEXP=8, WSIG=23); sticky-flag checks
// are compiled in when FPMUL_STICKY_FLAGS_EN is defined.
module tb_fpmul_assemble_pipe;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fpmul_assemble_pipe_if #(.WEXP(8), .WSIG(23)) bus ();

  fpmul_assemble_pipe #(.WEXP(8), .WSIG(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid        = 1'b0;
    bus.roundprod       = 23'd0;
    bus.shiftexp        = 8'd0;
    bus.sign            = 1'b0;
    bus.special         = 31'd0;
    bus.specialsign     = 1'b0;
    bus.specialcase     = 1'b0;
    bus.specialsigncase = 1'b0;
    bus.roundmode       = 2'b00;
    bus.overflow        = 1'b0;
  endtask

  task automatic drive_plain(input logic s, input logic [7:0] e, input logic [22:0] p);
    idle_inputs();
    bus.in_valid  = 1'b1;
    bus.sign      = s;
    bus.shiftexp  = e;
    bus.roundprod = p;
  endtask

  logic [31:0] ovf_exp [4];
  logic [31:0] sbq [$];

  initial begin
    int sent;
    int got;
    logic acc;
    logic drn;
    logic [31:0] beat_y;
    checks = 0;
    errors = 0;
    ovf_exp[0] = 32'hFF800000;
    ovf_exp[1] = 32'hFF7FFFFF;
    ovf_exp[2] = 32'hFF7FFFFF;
    ovf_exp[3] = 32'hFF800000;
    idle_inputs();
    bus.out_ready = 1'b1;
`ifdef FPMUL_STICKY_FLAGS_EN
    bus.flag_clr = 1'b0;
`endif
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_in_ready", bus.in_ready, 1'b1);
    check_eq("rst_y", bus.y, 32'h0);
    check_eq("rst_y_ovf", bus.y_ovf, 1'b0);
    check_eq("rst_y_special", bus.y_special, 1'b0);

    // 1: plain rounded result, one cycle latency
    drive_plain(1'b0, 8'h80, 23'h400000);
    step();
    check_eq("t1_valid", bus.out_valid, 1'b1);
    check_eq("t1_y", bus.y, 32'h40400000);
    check_eq("t1_flags", {bus.y_ovf, bus.y_special}, 2'b00);
    idle_inputs();
    step();
    check_eq("t1_drained", bus.out_valid, 1'b0);

    // 2: overflow under each rounding mode, negative product
    for (int rm = 0; rm < 4; rm++) begin
      idle_inputs();
      bus.in_valid  = 1'b1;
      bus.overflow  = 1'b1;
      bus.sign      = 1'b1;
      bus.shiftexp  = 8'h12;
      bus.roundprod = 23'h123456;
      bus.roundmode = 2'(rm);
      step();
      check_eq($sformatf("t2_y_rm%0d", rm), bus.y, ovf_exp[rm]);
      check_eq($sformatf("t2_ovf_rm%0d", rm), bus.y_ovf, 1'b1);
    end
    idle_inputs();
    step();

    // 3: special wins over overflow, special sign selected
    idle_inputs();
    bus.in_valid        = 1'b1;
    bus.specialcase     = 1'b1;
    bus.overflow        = 1'b1;
    bus.special         = 31'h7FC00000;
    bus.specialsigncase = 1'b1;
    bus.specialsign     = 1'b0;
    bus.sign            = 1'b1;
    step();
    check_eq("t3_y", bus.y, 32'h7FC00000);
    check_eq("t3_special", bus.y_special, 1'b1);
    check_eq("t3_ovf", bus.y_ovf, 1'b0);
    idle_inputs();
    step();

    // 4: 8-beat stream with out_ready low in cycles 2..4
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      bus.out_ready = !(c >= 2 && c <= 4);
      if (sent < 8) begin
        drive_plain(sent[0], 8'h10 + 8'(sent), 23'(sent + 1));
      end else begin
        idle_inputs();
      end
      beat_y = {sent[0], 8'h10 + 8'(sent), 23'(sent + 1)};
      if (c == 3) check_eq("t4_in_ready_stall", bus.in_ready, 1'b0);
      if (bus.out_valid) begin
        if (sbq.size() == 0) check_eq("t4_spurious", bus.out_valid, 1'b0);
        else check_eq($sformatf("t4_y_c%0d", c), bus.y, sbq[0]);
      end
      acc = bus.in_valid && bus.in_ready;
      drn = bus.out_valid && bus.out_ready;
      if (drn && sbq.size() > 0) begin
        void'(sbq.pop_front());
        got++;
      end
      step();
      if (acc) begin
        sbq.push_back(beat_y);
        sent++;
      end
    end
    check_eq("t4_count", got, 8);
    idle_inputs();
    bus.out_ready = 1'b1;
    step();

    // 5: reset with main and skid full, beat offered during reset is dropped
    bus.out_ready = 1'b0;
    drive_plain(1'b0, 8'h21, 23'h000AAA);
    step();
    drive_plain(1'b1, 8'h22, 23'h000BBB);
    step();
    check_eq("t5_full_in_ready", bus.in_ready, 1'b0);
    check_eq("t5_full_y", bus.y, 32'h10800AAA);
    drive_plain(1'b0, 8'h23, 23'h000CCC);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t5_out_valid", bus.out_valid, 1'b0);
    check_eq("t5_in_ready", bus.in_ready, 1'b1);
    check_eq("t5_y", bus.y, 32'h0);
    idle_inputs();
    bus.out_ready = 1'b1;
    step();
    check_eq("t5_discarded", bus.out_valid, 1'b0);

`ifdef FPMUL_STICKY_FLAGS_EN
    // 6: sticky overflow set, cleared, and set-wins against clear
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.overflow = 1'b1;
    step();
    idle_inputs();
    step();
    check_eq("t6_sticky_set", bus.sticky_ovf, 1'b1);
    check_eq("t6_sticky_spc", bus.sticky_special, 1'b0);
    bus.flag_clr = 1'b1;
    step();
    bus.flag_clr = 1'b0;
    check_eq("t6_sticky_clr", bus.sticky_ovf, 1'b0);
    bus.in_valid = 1'b1;
    bus.overflow = 1'b1;
    step();
    idle_inputs();
    bus.flag_clr = 1'b1;
    step();
    bus.flag_clr = 1'b0;
    check_eq("t6_set_wins", bus.sticky_ovf, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
